// File: rtl/key_debounce_ctrl.sv
// Push-button debouncer: shared sample-tick prescaler, 2-flop synchronizers and
// one stability FSM per button producing a debounced level plus press/release pulses.
//
// state          | meaning
// ---------------+---------------------------------------------------------
// ST_RELEASED    | debounced level is 0, sample agrees
// ST_PRESS_CHK   | level 0, counting consecutive 1 samples toward a press
// ST_PRESSED     | debounced level is 1, sample agrees
// ST_RELEASE_CHK | level 1, counting consecutive 0 samples toward a release
module key_debounce_ctrl #(
   parameter int N_BTN        = 5,
   parameter int TICK_DIV     = 524288,
   parameter int STABLE_TICKS = 3
) (
   input  logic             clk_100MHz,
   input  logic             clr,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic             tick
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CNT_W = $clog2(STABLE_TICKS + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RELEASED,
      ST_PRESS_CHK,
      ST_PRESSED,
      ST_RELEASE_CHK
   } btn_state_t;

   logic [DIV_W-1:0] div_cnt;
   logic [N_BTN-1:0] sync_q1;
   logic [N_BTN-1:0] sync_q2;
   btn_state_t       state [N_BTN];
   logic [CNT_W-1:0] cnt   [N_BTN];

   always_ff @(posedge clk_100MHz) begin
      if (clr) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk_100MHz) begin
      if (clr) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= btn_in;
         sync_q2 <= sync_q1;
      end
   end

   // Pulses default low every cycle, so they can only last the one cycle after a tick.
   always_ff @(posedge clk_100MHz) begin
      if (clr) begin
         for (int i = 0; i < N_BTN; i++) begin
            state[i] <= ST_RELEASED;
            cnt[i]   <= '0;
         end
         btn_level   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
      end else begin
         btn_press   <= '0;
         btn_release <= '0;
         if (tick) begin
            for (int i = 0; i < N_BTN; i++) begin
               case (state[i])
                  ST_RELEASED: begin
                     if (sync_q2[i]) begin
                        state[i] <= ST_PRESS_CHK;
                        cnt[i]   <= CNT_ONE;
                     end
                  end
                  ST_PRESS_CHK: begin
                     if (!sync_q2[i]) begin
                        state[i] <= ST_RELEASED;
                        cnt[i]   <= '0;
                     end else if (cnt[i] + CNT_ONE == CNT_DONE) begin
                        state[i]     <= ST_PRESSED;
                        cnt[i]       <= '0;
                        btn_level[i] <= 1'b1;
                        btn_press[i] <= 1'b1;
                     end else begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                     end
                  end
                  ST_PRESSED: begin
                     if (!sync_q2[i]) begin
                        state[i] <= ST_RELEASE_CHK;
                        cnt[i]   <= CNT_ONE;
                     end
                  end
                  ST_RELEASE_CHK: begin
                     if (sync_q2[i]) begin
                        state[i] <= ST_PRESSED;
                        cnt[i]   <= '0;
                     end else if (cnt[i] + CNT_ONE == CNT_DONE) begin
                        state[i]       <= ST_RELEASED;
                        cnt[i]         <= '0;
                        btn_level[i]   <= 1'b0;
                        btn_release[i] <= 1'b1;
                     end else begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                     end
                  end
                  default: begin
                     state[i] <= ST_RELEASED;
                     cnt[i]   <= '0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: doc/key_debounce_ctrl.md
KEY_DEBOUNCE_CTRL -- requirements
Module: key_debounce_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- N_BTN, 5, number of push-button inputs (1..16)
- TICK_DIV, 524288, sample-tick period in clk_100MHz cycles (>=2; 2^19 gives ~190 Hz)
- STABLE_TICKS, 3, consecutive equal samples required to accept a level change (2..15)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_100MHz, in, 1, sole clock; all logic on its rising edge
- clr, in, 1, reset, synchronous, active-high
- btn_in, in, N_BTN, raw asynchronous button levels, 1 = pressed
- btn_level, out, N_BTN, debounced level per button
- btn_press, out, N_BTN, one-cycle pulse on accepted 0->1 transition
- btn_release, out, N_BTN, one-cycle pulse on accepted 1->0 transition
- tick, out, 1, one-cycle sample strobe shared by all buttons
REQ-003 One clock; reset is synchronous and active-high. The block SHALL NOT generate derived clocks; sampling SHALL use the tick enable only.

Function
REQ-004 Prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be 1 exactly in cycles where the count equals TICK_DIV-1.
REQ-005 Each btn_in bit SHALL pass through a 2-flop synchronizer; the sample is the second flop's output.
REQ-006 Each button SHALL have an independent FSM and a stability counter of ceil(log2(STABLE_TICKS+1)) bits; the FSM and counter SHALL change only on tick cycles.
REQ-007 RELEASED: sample=1 -> PRESS_CHK, cnt=1; sample=0 -> stay.
REQ-008 PRESS_CHK: sample=1 and cnt+1==STABLE_TICKS -> PRESSED, cnt=0, btn_level=1, btn_press=1; sample=1 otherwise -> cnt+1; sample=0 -> RELEASED, cnt=0, no pulse.
REQ-009 PRESSED: sample=0 -> RELEASE_CHK, cnt=1; sample=1 -> stay.
REQ-010 RELEASE_CHK: sample=0 and cnt+1==STABLE_TICKS -> RELEASED, cnt=0, btn_level=0, btn_release=1; sample=0 otherwise -> cnt+1; sample=1 -> PRESSED, cnt=0, no pulse.
REQ-011 btn_level, btn_press and btn_release SHALL be registered and update on the clock edge that ends the tick cycle; pulses SHALL be high for exactly one cycle and 0 at all other times.
REQ-012 Latency: an input held stable from before a tick SHALL be accepted on the STABLE_TICKS-th consecutive tick that samples the new value; synchronizer delay is 2 cycles.
REQ-013 Glitches shorter than STABLE_TICKS sample periods SHALL produce no level change and no pulse.
REQ-014 Buttons SHALL be independent; any combination of press/release pulses MAY assert in the same cycle.
REQ-015 btn_press and btn_release for one button SHALL never be high in the same cycle.

Reset
REQ-016 clr=1 at a clock edge SHALL set the prescaler, synchronizers, counters and all outputs to 0, and all FSMs to RELEASED, taking priority over tick.
REQ-017 Reset mid-debounce or while PRESSED SHALL discard progress and emit no pulse; a button held through reset SHALL be re-accepted as a new press after release of clr.
REQ-018 tick SHALL first assert TICK_DIV cycles after the cycle in which clr deasserts.

Verification (bench uses TICK_DIV=4, STABLE_TICKS=3, N_BTN=5)
REQ-019 Deassert clr, btn_in=0 -> tick high every 4th cycle, first at cycle 4 after clr release; all outputs stay 0.
REQ-020 btn_in=5'b00001 held -> btn_level[0] rises and btn_press=5'b00001 for one cycle, at the 3rd tick sampling 1; btn_release stays 0.
REQ-021 btn_in[0] high for 2 ticks then low -> no pulse, btn_level stays 0; repeat with bouncing 1/0/1 each tick -> no pulse.
REQ-022 Buttons 1 and 3 pressed in the same cycle -> btn_press=5'b01010 in a single cycle; later release together -> btn_release=5'b01010.
REQ-023 clr pulsed while button 2 is in PRESSED, input still high -> btn_level=0 and no release pulse; press is re-accepted 3 ticks after reset with one btn_press[2] pulse.
REQ-024 Held button released -> btn_release pulse one cycle at the 3rd zero-sample tick; a 1-tick high glitch during RELEASE_CHK returns to PRESSED with no pulse.
